// File: rtl/mru_pkg.sv
// Shared definitions for the MRU unique-value encoder/decoder pair.
// Holds default sizes, the code type enum and the code struct.
package mru_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;
  localparam int DEFAULT_IDX_W  = $clog2(DEFAULT_DEPTH);

  typedef enum logic {
    CODE_LITERAL = 1'b0,
    CODE_HIT     = 1'b1
  } code_type_e;

  typedef struct packed {
    logic                      hit;
    logic [DEFAULT_IDX_W-1:0]  index;
    logic [DEFAULT_DATA_W-1:0] literal;
  } mru_code_t;

  function automatic code_type_e code_type_of(input logic hit);
    return hit ? CODE_HIT : CODE_LITERAL;
  endfunction

endpackage

// File: rtl/mru_table.sv
// DEPTH-entry move-to-front table with valid bits and a value match port.
// Shared between the MRU encoder and decoder so both sides evolve identically.
module mru_table
  import mru_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              update_en,
  input  logic              insert,
  input  logic [IDX_W-1:0]  slot,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              match_hit,
  output logic [IDX_W-1:0]  match_slot
);

  logic [DATA_W-1:0] entry_reg [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  match_vec;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_vec[gi] = valid_reg[gi] && (entry_reg[gi] == value);
    end
  endgenerate

  assign match_hit = |match_vec;

  always_comb begin
    match_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_vec[i]) match_slot = IDX_W'(i);
    end
  end

  // Slots beyond DEPTH (non-power-of-2 tables) read back as invalid.
  always_comb begin
    read_data  = '0;
    read_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot == IDX_W'(i)) begin
        read_data  = entry_reg[i];
        read_valid = valid_reg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else if (clear) begin
      valid_reg <= '0;
    end else if (update_en) begin
      entry_reg[0] <= insert ? value : read_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (insert || (IDX_W'(i) <= slot)) entry_reg[i] <= entry_reg[i-1];
      end
      if (insert) valid_reg <= {valid_reg[DEPTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mru_decoder.sv
// Receive-side MRU decoder: turns literal/hit codes back into data values,
// keeping a mirror of the encoder's move-to-front table.
module mru_decoder
  import mru_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              clear_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_hit,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [DATA_W-1:0] in_literal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err_out
);

  code_type_e        code_type;
  logic              accept;
  logic              produce;
  logic              table_insert;
  logic [IDX_W-1:0]  table_slot;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              match_hit;
  logic [IDX_W-1:0]  match_slot;
  logic [DATA_W-1:0] result;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              err_reg;

  assign code_type = code_type_of(in_hit);
  assign in_ready  = !clear_in && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;

  // A literal already in the table is handled exactly like a hit on its slot.
  assign table_insert = (code_type == CODE_LITERAL) && !match_hit;
  assign table_slot   = (code_type == CODE_HIT) ? in_index : match_slot;
  assign produce      = accept && (table_insert || read_valid);
  assign result       = table_insert ? in_literal : read_data;

  mru_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk        (clk_in),
    .rst_n      (reset_n_in),
    .clear      (clear_in),
    .update_en  (produce),
    .insert     (table_insert),
    .slot       (table_slot),
    .value      (in_literal),
    .read_data  (read_data),
    .read_valid (read_valid),
    .match_hit  (match_hit),
    .match_slot (match_slot)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= accept && (code_type == CODE_HIT) && !read_valid;
      if (produce) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= result;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign err_out   = err_reg;

endmodule

// File: tb/tb_mru_decoder.sv
// Directed self-checking bench for mru_decoder (DATA_W=8, DEPTH=4).
module tb_mru_decoder;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic       in_hit;
  logic [1:0] in_index;
  logic [7:0] in_literal;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       err_out;

  int tests_run = 0;
  int tests_failed = 0;

  mru_decoder #(.DATA_W(8), .DEPTH(4)) dut (
    .clk_in     (clk),
    .reset_n_in (reset_n),
    .clear_in   (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_hit     (in_hit),
    .in_index   (in_index),
    .in_literal (in_literal),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err_out    (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One code per call; outputs are checked 1 time unit after the accepting edge.
  task automatic send(input logic hit, input logic [1:0] idx, input logic [7:0] lit,
                      input logic exp_v, input logic [7:0] exp_d, input logic exp_e,
                      input string tag);
    @(negedge clk);
    in_valid   = 1'b1;
    in_hit     = hit;
    in_index   = idx;
    in_literal = lit;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, " out_valid"}, out_valid, exp_v);
    if (exp_v) check({tag, " out_data"}, out_data, exp_d);
    check({tag, " err_out"}, err_out, exp_e);
  endtask

  initial begin
    reset_n    = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_hit     = 1'b0;
    in_index   = '0;
    in_literal = '0;
    out_ready  = 1'b1;
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset err_out", err_out, 0);
    do_reset();
    check("post-reset in_ready", in_ready, 1);

    // Basic stream and move-to-front
    send(0, 0, 8'd1, 1, 8'd1, 0, "L1");
    send(0, 0, 8'd2, 1, 8'd2, 0, "L2");
    send(1, 1, 8'd0, 1, 8'd1, 0, "H1a");
    send(1, 1, 8'd0, 1, 8'd2, 0, "H1b");
    send(1, 1, 8'd0, 1, 8'd1, 0, "H1c");   // table [1,2]
    send(1, 1, 8'd0, 1, 8'd2, 0, "H1d");   // table [2,1]
    // Literal already present behaves as a hit, no duplicate inserted
    send(0, 0, 8'd1, 1, 8'd1, 0, "L1dup"); // table [1,2]
    send(1, 1, 8'd0, 1, 8'd2, 0, "H1e");   // table [2,1]
    send(1, 2, 8'd0, 0, 8'd0, 1, "H2inv");

    // Eviction of oldest entry
    do_reset();
    send(0, 0, 8'd1, 1, 8'd1, 0, "E L1");
    send(0, 0, 8'd2, 1, 8'd2, 0, "E L2");
    send(0, 0, 8'd3, 1, 8'd3, 0, "E L3");
    send(0, 0, 8'd4, 1, 8'd4, 0, "E L4");
    send(0, 0, 8'd5, 1, 8'd5, 0, "E L5");  // [5,4,3,2]
    send(1, 3, 8'd0, 1, 8'd2, 0, "E H3a"); // [2,5,4,3]
    send(1, 3, 8'd0, 1, 8'd3, 0, "E H3b"); // [3,2,5,4]
    send(1, 3, 8'd0, 1, 8'd4, 0, "E H3c"); // [4,3,2,5]
    send(1, 3, 8'd0, 1, 8'd5, 0, "E H3d"); // [5,4,3,2]
    send(0, 0, 8'd1, 1, 8'd1, 0, "E L1re"); // 1 was evicted: [1,5,4,3]
    send(1, 3, 8'd0, 1, 8'd3, 0, "E H3e");

    // Hit into empty table
    do_reset();
    send(1, 0, 8'd0, 0, 8'd0, 1, "X H0");
    @(posedge clk);
    #1;
    check("X err single pulse", err_out, 0);
    send(0, 0, 8'd7, 1, 8'd7, 0, "X L7");  // [7]

    // Backpressure
    send(0, 0, 8'd8, 1, 8'd8, 0, "B L8");  // [8,7]
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_hit     = 1'b0;
    in_literal = 8'd9;
    #1;
    check("B in_ready low", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("B hold valid", out_valid, 1);
      check("B hold data", out_data, 8'd8);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("B in_ready release", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("B L9 valid", out_valid, 1);
    check("B L9 data", out_data, 8'd9); // [9,8,7]
    send(1, 1, 8'd0, 1, 8'd8, 0, "B H1");  // [8,9,7]

    // Clear mid-stream: pending output still drains, table emptied
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_hit   = 1'b1;
    in_index = 2'd0;
    #1;
    check("C in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("C drained", out_valid, 0);
    check("C no err", err_out, 0);
    send(1, 0, 8'd0, 0, 8'd0, 1, "C H0");

    // Asynchronous reset mid-stream
    send(0, 0, 8'd3, 1, 8'd3, 0, "R L3");
    #2;
    reset_n = 1'b0;
    #1;
    check("R out_valid async", out_valid, 0);
    check("R out_data async", out_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    send(1, 0, 8'd0, 0, 8'd0, 1, "R H0");
    send(0, 0, 8'd5, 1, 8'd5, 0, "R L5");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
